// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with hi/lo, bypass and reset clear sweep
//
// Purpose: NRD combinational read ports, two GPR write ports (port 1 wins on
// an address clash), hi/lo special registers optionally mapped into the top two
// GPR addresses, optional same-cycle write-to-read forwarding, and a clear sweep
// after reset so the GPR array itself needs no reset.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rd_addr/rd_data   NRD packed read lanes (AW / DATA_W bits each)
//   we0/wa0/wd0       GPR write port 0
//   we1/wa1/wd1       GPR write port 1 (higher priority)
//   hi_we/hi_wd       hi write, lo_we/lo_wd lo write
//   hi, lo            registered hi/lo values (never forwarded)
//   busy              clear sweep in progress

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 3,
    parameter int BYPASS   = 1,
    parameter int HILO_MAP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  hi_we,
    input  logic [DATA_W-1:0]     hi_wd,
    input  logic                  lo_we,
    input  logic [DATA_W-1:0]     lo_wd,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic                  busy
);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam logic [AW-1:0] ADDR_LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0] ADDR_HI   = AW'(NREGS - 2);
    localparam logic [AW-1:0] ADDR_LO   = AW'(NREGS - 1);

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    // Non-resettable storage; zeroed by the sweep instead.
    logic [DATA_W-1:0]   regs [NREGS];

    logic                busy_int;
    logic                accept;
    logic                w0_ok, w1_ok, hi_ok, lo_ok;
    logic                clr_we;
    logic [AW-1:0]       clr_addr;

    // Address 0 is hardwired zero; the hi/lo mapped slots never hold GPR data.
    function automatic logic gpr_writable(input logic [AW-1:0] a);
        return (a != '0) && !((HILO_MAP != 0) && (a >= ADDR_HI));
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_CLEAR) begin
            if (ptr_q == ADDR_LAST) begin
                state_d = ST_READY;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        busy_int = (state_q == ST_CLEAR);
    end

    // Write qualification. Writes coinciding with rst are dropped, and a
    // dropped write is also never forwarded to the read lanes.
    always_comb begin
        accept   = !rst && !busy_int;
        w0_ok    = accept && we0 && gpr_writable(wa0);
        w1_ok    = accept && we1 && gpr_writable(wa1);
        hi_ok    = accept && hi_we;
        lo_ok    = accept && lo_we;
        hi_d     = hi_ok ? hi_wd : hi_q;
        lo_d     = lo_ok ? lo_wd : lo_q;
        // Held reset keeps re-clearing entry 0 while ptr is pinned at 0.
        clr_we   = rst || busy_int;
        clr_addr = rst ? '0 : ptr_q;
    end

    // Port 1 is written last so it wins a same-address clash.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[clr_addr] <= '0;
        end else begin
            if (w0_ok) regs[wa0] <= wd0;
            if (w1_ok) regs[wa1] <= wd1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] rv;

        always_comb begin
            ra = rd_addr[k*AW +: AW];
            rv = regs[ra];
            if (busy_int) begin
                rv = '0;
            end else if (ra == '0) begin
                rv = '0;
            end else if ((HILO_MAP != 0) && (ra == ADDR_HI)) begin
                rv = ((BYPASS != 0) && hi_ok) ? hi_wd : hi_q;
            end else if ((HILO_MAP != 0) && (ra == ADDR_LO)) begin
                rv = ((BYPASS != 0) && lo_ok) ? lo_wd : lo_q;
            end else if ((BYPASS != 0) && w1_ok && (wa1 == ra)) begin
                rv = wd1;
            end else if ((BYPASS != 0) && w0_ok && (wa0 == ra)) begin
                rv = wd0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_int;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the next Mini-MIPS core revision (dual-issue datapath).
- NRD combinational read ports and two write ports.
- hi/lo special registers, readable through mapped addresses.
- Optional write-to-read bypass.
- Reset-triggered clear sweep FSM with a busy flag, so the storage array can be a non-resettable RAM.

Parameters:
DATA_W, 32, data width of every register, hi and lo
NREGS, 32, number of GPRs (power of 2, >= 4)
AW, 5, address width, = log2(NREGS)
NRD, 3, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored values only
HILO_MAP, 1, 1 = read address NREGS-2 returns hi and NREGS-1 returns lo; GPR writes to those addresses are discarded

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rd_data  out  NRD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
we0  in  1  write enable, port 0
wa0  in  AW  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  AW  write address, port 1
wd1  in  DATA_W  write data, port 1
hi_we  in  1  hi write enable
hi_wd  in  DATA_W  hi write data
lo_we  in  1  lo write enable
lo_wd  in  DATA_W  lo write data
hi  out  DATA_W  current hi register
lo  out  DATA_W  current lo register
busy  out  1  clear sweep in progress

Behaviour:
- FSM states: CLEAR, READY.
- Reset, at a posedge with rst=1:
  - state<=CLEAR, ptr<=0, hi<=0, lo<=0, busy=1.
  - The array is not reset directly.
  - While rst is held: ptr stays 0 and regs[0]<=0 every cycle.
- CLEAR, with rst=0: each posedge writes regs[ptr]<=0 and increments ptr.
  - On the edge that clears ptr==NREGS-1: state<=READY, ptr<=0.
  - busy is high for exactly NREGS posedges after rst falls; busy=(state==CLEAR).
- While busy:
  - All write ports are ignored, including hi_we/lo_we.
  - Every rd_data lane reads 0.
- READY writes (posedge):
  - weN && waN!=0 && !(HILO_MAP && waN>=NREGS-2): regs[waN]<=wdN.
  - If both ports target the same address, port 1 wins.
  - hi_we: hi<=hi_wd. lo_we: lo<=lo_wd. These are independent of GPR writes.
- Reads are combinational, zero latency. Per port, in priority order:
  1. busy -> 0.
  2. addr==0 -> 0.
  3. HILO_MAP && addr==NREGS-2 -> hi, or hi_wd if BYPASS && hi_we.
  4. HILO_MAP && addr==NREGS-1 -> lo, or lo_wd if BYPASS && lo_we.
  5. BYPASS && we1 && wa1==addr -> wd1.
  6. BYPASS && we0 && wa0==addr -> wd0.
  7. Otherwise regs[addr].
- Discarded writes are never forwarded: address 0, hilo-mapped addresses, and any write while busy.
- The hi/lo outputs always show registered values; they are never bypassed.
- rst asserted mid-sweep restarts the sweep from ptr=0.
- rst asserted during READY discards any same-cycle writes.
- Widths: no truncation or extension; all data paths are DATA_W.

Test Plan:
- Assert rst 2 cycles then release; count cycles -> busy=1 for exactly 32 posedges, then 0; all rd_data=0 throughout; hi=lo=0.
- While busy, we0=1 wa0=5 wd0=0xDEAD; after READY read addr 5 -> 0x00000000.
- READY, same cycle we0=1 wa0=7 wd0=0x11111111 and we1=1 wa1=7 wd1=0x22222222, read port 0 addr 7:
  - same cycle (BYPASS=1) -> 0x22222222;
  - next cycle -> 0x22222222.
- Write wa1=0 wd1=0xFFFFFFFF -> read addr 0 = 0 in that cycle and after. Write wa0=30 wd0=0x1234 -> addr 30 still returns hi.
- hi_we=1 hi_wd=0xABCD0000 with read port 2 addr 30 -> rd_data lane 2 = 0xABCD0000 in the same cycle; hi output updates the next cycle. Repeat with BYPASS=0 -> lane shows the old hi (0) in the same cycle.
- Mid-sweep rst pulse at ptr=10 -> busy extends to 32 cycles after the second release.
